// File: rtl/uart_tx_queue_pkg.sv
// Shared UART transmit-queue constants: default geometry and drain FSM state encodings.
package uart_tx_queue_pkg;

  localparam int WDATA_DEFAULT = 8;
  localparam int DEPTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/uart_tx_queue_if.sv
// Host-side and transmitter-side signals of the buffered UART transmitter.
interface uart_tx_queue_if #(
  parameter int Wdata = 8,
  parameter int Depth = 16
);
  logic [Wdata-1:0]       wdata;
  logic                   we;
  logic                   ovf_clr;
  logic                   rdy;
  logic                   full;
  logic                   empty;
  logic [$clog2(Depth):0] count;
  logic                   ovf;
  logic [Wdata-1:0]       din;
  logic                   oe;

  modport master (
    output wdata, we, ovf_clr, rdy,
    input  full, empty, count, ovf, din, oe
  );

  modport slave (
    input  wdata, we, ovf_clr, rdy,
    output full, empty, count, ovf, din, oe
  );
endinterface

// File: rtl/uart_tx_queue_sync_fifo.sv
// Circular-buffer FIFO with registered FULL/EMPTY/COUNT; writes at FULL are dropped.
module sync_fifo
  import uart_tx_queue_pkg::*;
#(
  parameter int Wdata = WDATA_DEFAULT,
  parameter int Depth = DEPTH_DEFAULT
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [Wdata-1:0]       i_wdata,
  input  logic                   i_we,
  input  logic                   i_pop,
  output logic [Wdata-1:0]       o_rdata,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(Depth):0] o_count,
  output logic                   o_ovf_hit
);

  localparam int AW = $clog2(Depth);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(Depth);

  logic [Wdata-1:0] r_mem [Depth];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_count;
  logic             r_full;
  logic             r_empty;

  logic             w_wr;
  logic             w_rd;
  logic [AW:0]      w_count_nxt;

  // Acceptance uses the registered flags, so a pop cannot make room for a same-cycle write.
  assign w_wr = i_we & ~r_full;
  assign w_rd = i_pop & ~r_empty;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr, w_rd})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_wr && !i_rst) begin
      r_mem[r_wr] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_wr) r_wr <= r_wr + 1'b1;
      if (w_rd) r_rd <= r_rd + 1'b1;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_FULL);
      r_empty <= (w_count_nxt == '0);
    end
  end

  assign o_rdata   = r_mem[r_rd];
  assign o_full    = r_full;
  assign o_empty   = r_empty;
  assign o_count   = r_count;
  assign o_ovf_hit = i_we & r_full;

endmodule

// File: rtl/uart_tx_queue.sv
// Buffered UART transmit front end: host queue plus a drain FSM that hands one
// character at a time to the transmitter, waiting for RDY to drop between loads.
module uart_tx_queue
  import uart_tx_queue_pkg::*;
#(
  parameter int Wdata = WDATA_DEFAULT,
  parameter int Depth = DEPTH_DEFAULT
) (
  input  logic      i_clk,
  input  logic      i_rst,
  uart_tx_queue_if.slave bus
);

  localparam int CW = $clog2(Depth) + 1;

  state_t           r_state;
  logic [Wdata-1:0] r_din;
  logic             r_oe;
  logic             r_ovf;

  logic [Wdata-1:0] w_rdata;
  logic             w_full;
  logic             w_empty;
  logic [CW-1:0]    w_count;
  logic             w_ovf_hit;
  logic             w_pop;

  assign w_pop = (r_state == ST_IDLE) & bus.rdy & ~w_empty;

  sync_fifo #(
    .Wdata (Wdata),
    .Depth (Depth)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_wdata   (bus.wdata),
    .i_we      (bus.we),
    .i_pop     (w_pop),
    .o_rdata   (w_rdata),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_count   (w_count),
    .o_ovf_hit (w_ovf_hit)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_din   <= '0;
      r_oe    <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      // A new overflow wins over a coincident clear.
      if (w_ovf_hit)        r_ovf <= 1'b1;
      else if (bus.ovf_clr) r_ovf <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          r_oe <= 1'b0;
          if (w_pop) begin
            r_din   <= w_rdata;
            r_oe    <= 1'b1;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_oe    <= 1'b0;
          r_state <= ST_HOLD;
        end
        ST_HOLD: begin
          r_oe <= 1'b0;
          if (!bus.rdy) r_state <= ST_IDLE;
        end
        default: begin
          r_oe    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.full  = w_full;
  assign bus.empty = w_empty;
  assign bus.count = w_count;
  assign bus.ovf   = r_ovf;
  assign bus.din   = r_din;
  assign bus.oe    = r_oe;

endmodule

// File: doc/uart_tx_queue.md
UART_TX_QUEUE -- requirements
Module: uart_tx_queue

Interface
REQ-001 Parameter Wdata, default 8, character width in bits; SHALL match the Wdata of the downstream UART transmitter.
REQ-002 Parameter Depth, default 16, queue capacity in entries; SHALL be a power of two, minimum 2.
REQ-003 CLK  input  1  sole clock; all state updates on its rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 WDATA  input  Wdata  character from the host.
REQ-006 WE  input  1  host write strobe; one character per cycle while high.
REQ-007 FULL  output  1  queue holds Depth entries.
REQ-008 EMPTY  output  1  queue holds 0 entries.
REQ-009 COUNT  output  log2(Depth)+1  current occupancy, 0..Depth.
REQ-010 OVF  output  1  sticky overflow flag.
REQ-011 OVF_CLR  input  1  clears OVF.
REQ-012 DIN  output  Wdata  character to the UART transmitter, registered.
REQ-013 OE  output  1  one-cycle load strobe to the UART transmitter.
REQ-014 RDY  input  1  transmitter idle and able to accept a character.

Function
REQ-015 Storage SHALL be a circular buffer with wr/rd pointers of log2(Depth) bits wrapping Depth-1 -> 0; COUNT is a separate register.
REQ-016 A write SHALL be accepted when WE=1 and the registered FULL=0; the entry is stored at wr and wr advances.
REQ-017 WE=1 with FULL=1 SHALL discard WDATA, leave the contents unchanged, and set OVF, even if a pop occurs in the same cycle.
REQ-018 OVF SHALL stay set until OVF_CLR=1 or RST; if OVF_CLR and a new overflow coincide, OVF ends set.
REQ-019 A simultaneous accepted write and pop SHALL leave COUNT unchanged; the pointers move independently.
REQ-020 FULL, EMPTY and COUNT SHALL be registered and reflect the contents after the previous edge.
REQ-021 The drain FSM SHALL have three states: IDLE, ISSUE and HOLD.
REQ-022 IDLE: when RDY=1 and EMPTY=0, the FSM SHALL load the entry at rd into DIN, advance rd, decrement COUNT, and go to ISSUE; otherwise it stays in IDLE.
REQ-023 ISSUE: OE=1 for exactly this one cycle, then the FSM goes unconditionally to HOLD.
REQ-024 HOLD: OE=0; the FSM SHALL go to IDLE on the first cycle with RDY=0 (transmitter acknowledged) and stay in HOLD while RDY=1.
REQ-025 DIN SHALL stay stable from its load until the next load.
REQ-026 OE SHALL be 0 in IDLE and HOLD.
REQ-027 Latency: with the queue empty, FSM in IDLE and RDY=1, a write at edge t SHALL produce OE=1 in cycle t+2.
REQ-028 Back-to-back characters SHALL be separated by at least one full RDY low period; no second OE may occur without an intervening RDY=0.

Reset
REQ-029 While RST=1 at an edge, the block SHALL set wr=rd=0, COUNT=0, EMPTY=1, FULL=0, OVF=0, DIN=0, OE=0 and state=IDLE; WE is ignored that cycle.
REQ-030 RST during ISSUE or HOLD SHALL abandon the in-flight character and discard all queued entries; no OE may follow within the reset cycle.

Structure
REQ-031 The FSM state encodings (IDLE, ISSUE, HOLD) SHALL live in the shared UART include header alongside the other UART constants.
REQ-032 Storage and pointer logic SHALL be one sub-module, sync_fifo (parameters Wdata and Depth), instantiated once.
REQ-033 The drain FSM SHALL be in uart_tx_queue itself, so that uart_tx_queue plus UART form a buffered transmitter.

Verification
REQ-034 Single char: after reset, WDATA=8'h55, WE for 1 cycle, RDY=1 -> OE high exactly 2 cycles after the write edge, DIN=8'h55, EMPTY=1 afterwards.
REQ-035 Fill/overflow: RDY=0, write 17 values 0x00..0x10 at Depth=16 -> FULL=1, COUNT=16, OVF=1, and 0x10 is never transmitted.
REQ-036 Drain order: from a full queue, toggle RDY like a 115200-baud transmitter -> OE pulses carry 0x00..0x0F in order, each preceded by RDY=1 and followed by RDY=0.
REQ-037 Simultaneous: COUNT=16, pop and WE in the same cycle -> write rejected, OVF=1, COUNT=15.
REQ-038 Wrap-around: 40 chars written/drained interleaved at Depth=4 -> all 40 transmitted in order, COUNT never exceeds 4.
REQ-039 Reset mid-op: assert RST in HOLD with COUNT=5 -> next cycle COUNT=0, OE=0, state=IDLE, no further OE until a new write.
